seg7_scan_driver: RTL and testbench

Multi-digit, time-multiplexed 7-segment display driver. It generalises the single-digit BCD-to-segment decoder to DIGITS digits. Per-digit value/decimal-point registers are loaded through a write port, and the block scans them with a prescaled digit counter. Guard cycles prevent ghosting, and optional leading-zero suppression blanks unused high digits. It sits between the datapath and the board's display pins.

---
 rtl/seg7_scan_driver_if.sv | 26 ++
 rtl/seg7_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display driver bus: digit register write port, leading-zero control and
// the multiplexed segment/digit-enable pins.
// The master side is the datapath/board model; the slave side is the driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    localparam int AW = $clog2(DIGITS);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [4:0]        wr_data;
    logic              lz_en;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;

    modport master (
        output wr_en, wr_addr, wr_data, lz_en,
        input  seg, dp, an
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, lz_en,
        output seg, dp, an
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multi-digit time-multiplexed 7-segment driver.
// A per-digit register file (value + decimal point) is scanned by a prescaled
// digit index; the last GUARD cycles of every slot turn all digit enables off
// to avoid ghosting. seg/dp/an are registered.
// Optional build macro SEG7_HEX_DECODE_EN: when defined, values 10..15 show
// A,b,C,d,E,F; otherwise they are blanked.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);
    localparam int AW       = $clog2(DIGITS);
    localparam int PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ON_LIMIT = SCAN_DIV - GUARD;

    // IDLE covers the single cycle after reset release during which the
    // outputs stay at their reset values before the scan starts.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               scan_en_s;
    logic [PW-1:0]      presc_r;
    logic [PW-1:0]      presc_s;
    logic [AW-1:0]      idx_r;
    logic [AW-1:0]      idx_s;
    logic [4:0]         digit_r [DIGITS];
    logic [4:0]         cur_s;
    logic               hi_nz_s;
    logic               blank_s;
    logic               wr_hit_s;
    logic [6:0]         seg_s;
    logic               dp_s;
    logic [DIGITS-1:0]  an_s;
    logic [6:0]         seg_r;
    logic               dp_r;
    logic [DIGITS-1:0]  an_r;

    // Active-high segment pattern {A,B,C,D,E,F,G} for a 4-bit digit value.
    function automatic logic [6:0] decode_digit(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
`ifdef SEG7_HEX_DECODE_EN
            4'd10:   pat = 7'b1110111;
            4'd11:   pat = 7'b0011111;
            4'd12:   pat = 7'b1001110;
            4'd13:   pat = 7'b0111101;
            4'd14:   pat = 7'b1001111;
            4'd15:   pat = 7'b1000111;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
                     pat = 7'b0000000;
`endif
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    // Scan sequencer next state: one idle cycle after reset, then scan forever.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = ST_SCAN;
            ST_SCAN: state_s = ST_SCAN;
            default: state_s = ST_IDLE;
        endcase
        scan_en_s = (state_r == ST_SCAN);
    end

    // Prescaler and digit index advance; index moves on the last slot cycle.
    always_comb begin
        presc_s = presc_r;
        idx_s   = idx_r;
        if (scan_en_s) begin
            if (presc_r == PW'(SCAN_DIV - 1)) begin
                presc_s = '0;
                if (idx_r == AW'(DIGITS - 1)) begin
                    idx_s = '0;
                end else begin
                    idx_s = idx_r + AW'(1);
                end
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = presc_r;
            idx_s   = idx_r;
        end
    end

    // Leading-zero detect: any non-zero value at or above the current digit.
    always_comb begin
        hi_nz_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx_r)) && (digit_r[i][3:0] != 4'd0)) begin
                hi_nz_s = 1'b1;
            end else begin
                hi_nz_s = hi_nz_s;
            end
        end
        blank_s = bus.lz_en && !hi_nz_s && (idx_r != AW'(0));
    end

    // Next display values from the current index/prescaler and digit registers.
    always_comb begin
        cur_s    = digit_r[idx_r];
        wr_hit_s = bus.wr_en && (int'(bus.wr_addr) < DIGITS);
        seg_s    = 7'b0000000;
        dp_s     = 1'b0;
        an_s     = '0;
        if (scan_en_s) begin
            dp_s = cur_s[4];
            if (int'(presc_r) < ON_LIMIT) begin
                an_s = DIGITS'(1) << idx_r;
            end else begin
                an_s = '0;
            end
            if (blank_s) begin
                seg_s = 7'b0000000;
            end else begin
                seg_s = decode_digit(cur_s[3:0]);
            end
        end else begin
            seg_s = 7'b0000000;
            dp_s  = 1'b0;
            an_s  = '0;
        end
    end

    // State, counters, digit register file and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            presc_r <= '0;
            idx_r   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                digit_r[i] <= 5'd0;
            end
            seg_r   <= 7'b0000000;
            dp_r    <= 1'b0;
            an_r    <= '0;
        end else begin
            state_r <= state_s;
            presc_r <= presc_s;
            idx_r   <= idx_s;
            if (wr_hit_s) begin
                digit_r[bus.wr_addr] <= bus.wr_data;
            end
            seg_r   <= seg_s;
            dp_r    <= dp_s;
            an_r    <= an_s;
        end
    end

    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;
    assign bus.an  = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4, GUARD=1).
// An independent cycle model pushes the expected seg/dp/an for every edge
// into a scoreboard queue; after the edge it is popped and compared.
// Directed spot checks against literal patterns follow the test plan.
module tb_seg7_scan_driver;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int GUARD    = 1;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    exp_t sb_q [$];

    logic [4:0] m_digit [DIGITS];
    int         m_presc;
    int         m_idx;
    bit         m_run;

    logic [6:0] dec_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011,
`ifdef SEG7_HEX_DECODE_EN
        7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101,
        7'b1001111, 7'b1000111
`else
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000
`endif
    };

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .GUARD   (GUARD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict, advance the model, clock the DUT, compare.
    task automatic tick();
        exp_t       e;
        logic [4:0] cur;
        bit         hi_nz;
        e = '0;
        if (rst_n && m_run) begin
            cur   = m_digit[m_idx];
            e.an  = (m_presc < SCAN_DIV - GUARD) ? 4'(1 << m_idx) : 4'b0000;
            hi_nz = 1'b0;
            for (int j = m_idx; j < DIGITS; j++)
                if (m_digit[j][3:0] != 4'd0) hi_nz = 1'b1;
            e.seg = (bus.lz_en && m_idx != 0 && !hi_nz) ? 7'b0000000 : dec_tab[cur[3:0]];
            e.dp  = cur[4];
        end
        sb_q.push_back(e);
        if (!rst_n) begin
            for (int j = 0; j < DIGITS; j++) m_digit[j] = 5'd0;
            m_presc = 0;
            m_idx   = 0;
            m_run   = 1'b0;
        end else begin
            if (bus.wr_en) m_digit[bus.wr_addr] = bus.wr_data;
            if (m_run) begin
                if (m_presc == SCAN_DIV - 1) begin
                    m_presc = 0;
                    m_idx   = (m_idx + 1) % DIGITS;
                end else begin
                    m_presc++;
                end
            end
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_seg", 32'(bus.seg), 32'(e.seg));
        check("sb_dp",  32'(bus.dp),  32'(e.dp));
        check("sb_an",  32'(bus.an),  32'(e.an));
    endtask

    task automatic write_digit(input logic [1:0] addr, input logic [4:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Clock until the digit enables equal target, bounded.
    task automatic wait_an(input logic [3:0] target, input string tag);
        int n;
        n = 0;
        while (bus.an !== target && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_reach"}, 32'(bus.an), 32'(target));
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 5'd0;
        bus.lz_en   = 1'b0;
        for (int j = 0; j < DIGITS; j++) m_digit[j] = 5'd0;
        m_presc = 0;
        m_idx   = 0;
        m_run   = 1'b0;

        // 1: reset held, then release timing
        repeat (3) tick();
        check("rst_an",  32'(bus.an),  32'(4'b0000));
        check("rst_seg", 32'(bus.seg), 32'(7'b0000000));
        check("rst_dp",  32'(bus.dp),  32'(1'b0));
        rst_n = 1'b1;
        tick();
        check("rel1_an", 32'(bus.an), 32'(4'b0000));
        tick();
        check("rel2_an",  32'(bus.an),  32'(4'b0001));
        check("rel2_seg", 32'(bus.seg), 32'(7'b1111110));

        // 2: digits 0..3 = 0,1,2,3
        write_digit(2'd0, 5'd0);
        write_digit(2'd1, 5'd1);
        write_digit(2'd2, 5'd2);
        write_digit(2'd3, 5'd3);
        repeat (32) tick();
        wait_an(4'b0100, "t2_d2");
        check("t2_d2_seg", 32'(bus.seg), 32'(7'b1101101));
        wait_an(4'b1000, "t2_d3");
        check("t2_d3_seg", 32'(bus.seg), 32'(7'b1111001));
        repeat (3) tick();
        check("t2_guard_an",  32'(bus.an),  32'(4'b0000));
        check("t2_guard_seg", 32'(bus.seg), 32'(7'b1111001));
        tick();
        check("t2_wrap_an", 32'(bus.an), 32'(4'b0001));

        // 3: hex value with decimal point
        write_digit(2'd0, 5'b1_1010);
        wait_an(4'b0010, "t3_pre");
        wait_an(4'b0001, "t3_d0");
`ifdef SEG7_HEX_DECODE_EN
        check("t3_seg", 32'(bus.seg), 32'(7'b1110111));
`else
        check("t3_seg", 32'(bus.seg), 32'(7'b0000000));
`endif
        check("t3_dp", 32'(bus.dp), 32'(1'b1));

        // 4: leading-zero suppression
        bus.lz_en = 1'b1;
        write_digit(2'd3, 5'd0);
        write_digit(2'd2, 5'd0);
        write_digit(2'd1, 5'd0);
        write_digit(2'd0, 5'd7);
        wait_an(4'b1000, "t4_d3");
        check("t4_d3_seg", 32'(bus.seg), 32'(7'b0000000));
        wait_an(4'b0100, "t4_d2");
        check("t4_d2_seg", 32'(bus.seg), 32'(7'b0000000));
        wait_an(4'b0010, "t4_d1");
        check("t4_d1_seg", 32'(bus.seg), 32'(7'b0000000));
        wait_an(4'b0001, "t4_d0");
        check("t4_d0_seg", 32'(bus.seg), 32'(7'b1110000));
        write_digit(2'd0, 5'd0);
        wait_an(4'b0010, "t4_z_pre");
        wait_an(4'b0001, "t4_z_d0");
        check("t4_z_d0_seg", 32'(bus.seg), 32'(7'b1111110));

        // 5: write digit1 on the edge that enters slot 1
        n = 0;
        while (!(m_run && m_presc == SCAN_DIV - 1 && m_idx == 0) && n < 40) begin
            tick();
            n++;
        end
        check("t5_align", 32'(n < 40), 32'(1));
        write_digit(2'd1, 5'd5);
        tick();
        check("t5_an",  32'(bus.an),  32'(4'b0010));
        check("t5_seg", 32'(bus.seg), 32'(7'b1011011));
        repeat (2) tick();
        check("t5_an_hold", 32'(bus.an), 32'(4'b0010));
        tick();
        check("t5_guard", 32'(bus.an), 32'(4'b0000));

        // 6: reset mid-scan
        write_digit(2'd2, 5'd9);
        wait_an(4'b0100, "t6_d2");
        rst_n = 1'b0;
        tick();
        check("t6_rst_an",  32'(bus.an),  32'(4'b0000));
        check("t6_rst_seg", 32'(bus.seg), 32'(7'b0000000));
        rst_n = 1'b1;
        tick();
        check("t6_rel1_an", 32'(bus.an), 32'(4'b0000));
        tick();
        check("t6_rel2_an",  32'(bus.an),  32'(4'b0001));
        check("t6_rel2_seg", 32'(bus.seg), 32'(7'b1111110));
        wait_an(4'b0100, "t6_cleared");
        check("t6_d2_blank", 32'(bus.seg), 32'(7'b0000000));
        bus.lz_en = 1'b0;
        repeat (16) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
